rv32_fetch_buffer: RTL and testbench
====================================

RV32_FETCH_BUFFER -- requirements
Module: rv32_fetch_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >=2.
REQ-003 SHALL have parameter MAX_OUTST, default 2, max in-flight fetch requests, 1..DEPTH.
REQ-004 SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-005 SHALL have one clock and an asynchronous active-low reset; ports clk and rst_n.
REQ-006 SHALL have ports, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- pc_fetch  out  XLEN  fetch address
- fetch_req  out  1  fetch request
- fetch_gnt  in  1  request accepted this cycle
- code_valid  in  1  in-order response valid
- code_fetch  in  XLEN  response instruction
- flush  in  1  discard buffer and in-flight responses
- redirect_pc  in  XLEN  new fetch address, used with flush
- halt  in  1  stop issuing new requests
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head (~stall)
- code_out  out  XLEN  head instruction
- pc_out  out  XLEN  head PC
- level  out  $clog2(DEPTH)+1  occupied entries

Function
REQ-007 SHALL issue fetch_req when !halt && !flush && (level + outstanding) < DEPTH && outstanding < MAX_OUTST.
REQ-008 SHALL advance pc_fetch by 4 on fetch_req && fetch_gnt; pc_fetch SHALL hold while a request is not granted.
REQ-009 SHALL record each granted PC in an in-flight PC queue; the oldest PC SHALL pair with the next code_valid.
REQ-010 SHALL write {code_fetch, paired PC} into the FIFO on code_valid when the drop counter is zero.
REQ-011 SHALL pop the head on out_valid && out_ready; out_valid = (level != 0).
REQ-012 SHALL support simultaneous push and pop at full or empty with level unchanged and no data loss.
REQ-013 SHALL wrap read/write pointers modulo DEPTH using an extra MSB for full/empty.
REQ-014 On flush SHALL, in the next cycle: empty the FIFO, set pc_fetch = redirect_pc, load the drop counter with outstanding minus any response arriving in the flush cycle, and issue no request in the flush cycle.
REQ-015 SHALL decrement the drop counter on each code_valid while nonzero and discard that response.
REQ-016 Flush SHALL take priority over push, pop and grant in the same cycle.
REQ-017 A code_valid with zero outstanding SHALL be ignored; this is illegal upstream behaviour.
REQ-018 halt SHALL block new requests only; in-flight responses SHALL still be buffered.

Reset
REQ-019 On rst_n low SHALL set pc_fetch=RESET_PC, fetch_req=0, out_valid=0, level=0, outstanding=0, drop=0, code_out=0, pc_out=0.
REQ-020 Reset mid-transaction SHALL abandon all in-flight responses without a drop count.

Configuration
REQ-021 Macro FETCH_BUF_BYPASS_EN: when defined, a code_valid arriving with the FIFO empty and out_ready high SHALL drive code_out/pc_out combinationally with out_valid=1 and SHALL NOT be stored (zero-cycle latency).
REQ-022 When FETCH_BUF_BYPASS_EN is undefined, every response SHALL be registered; minimum response-to-out_valid latency is 1 cycle.

Structure
REQ-023 SHALL place RESET_PC default, the PC increment constant and the fetch entry struct {code, pc} in package rv32_pkg.
REQ-024 SHALL instantiate one sub-module, rv32_sync_fifo (parametrised width and depth), for the FIFO; the in-flight PC queue and drop counter stay in the top.

Verification
REQ-025 Reset, gnt=1, 1-cycle response, out_ready=1 -> pc_out sequence 0,4,8,12; level <=1.
REQ-026 out_ready=0, DEPTH=4 -> exactly 4 entries buffered, fetch_req=0, level=4; ready high -> PCs 0..12 drained in order.
REQ-027 2 requests outstanding, flush with redirect_pc=0x100 -> both late responses dropped; first out pc_out=0x100.
REQ-028 Full FIFO plus push and pop in the same cycle -> level stays 4; order preserved.
REQ-029 halt=1 with 1 outstanding -> response buffered; no further fetch_req until halt=0.
REQ-030 FETCH_BUF_BYPASS_EN defined, empty FIFO -> out_valid in the same cycle as code_valid; undefined -> one cycle later.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared constants and the fetch entry layout for the RV32 fetch buffer.
// No logic; types only.
// Entry packs {code, pc} with code in the upper half.
package rv32_pkg;
   localparam int FB_XLEN = 32;
   localparam logic [FB_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [FB_XLEN-1:0] PC_INCR          = 32'd4;

   typedef struct packed {
      logic [FB_XLEN-1:0] code;
      logic [FB_XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a synchronous clear.
// Latency: one cycle from write to visibility at rd_dat.
// Backpressure: write while full is accepted only with a same-cycle read; clear wins over both.
module rv32_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_dat,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd = rd_en && !empty && !clear;
   assign do_wr = wr_en && (!full || do_rd) && !clear;
   assign level = wr_ptr - rd_ptr;
   assign rd_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end
endmodule

// File: rtl/rv32_fetch_buffer.sv
// Instruction fetch buffer: issues in-order fetches, pairs responses with PCs, queues them for decode.
// Latency: response to out_valid is 1 cycle; 0 cycles through the bypass when FETCH_BUF_BYPASS_EN is defined.
// Backpressure: out_ready low fills the FIFO; requests stop once level plus in-flight reaches DEPTH.
module rv32_fetch_buffer
   import rv32_pkg::*;
#(
   parameter int              XLEN      = FB_XLEN,
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUTST = 2,
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic [XLEN-1:0]          pc_fetch,
   output logic                     fetch_req,
   input  logic                     fetch_gnt,
   input  logic                     code_valid,
   input  logic [XLEN-1:0]          code_fetch,
   input  logic                     flush,
   input  logic [XLEN-1:0]          redirect_pc,
   input  logic                     halt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          code_out,
   output logic [XLEN-1:0]          pc_out,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam int LW1 = LW + 1;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pcq [DEPTH];
   logic [AW-1:0]   pcq_wr;
   logic [AW-1:0]   pcq_rd;
   logic [LW-1:0]   live_cnt;
   logic [LW-1:0]   drop_cnt;
   logic [LW-1:0]   inflight;
   logic [LW:0]     room_sum;
   logic            run_q;
   logic            granted;
   logic            accept;
   logic            drop_hit;
   logic            resp_hit;
   logic            byp_take;
   logic            fifo_empty;
   fetch_entry_t    wr_ent;
   fetch_entry_t    rd_ent;

   // inflight counts every request still on the bus, including ones that will be dropped
   assign inflight = live_cnt + drop_cnt;
   assign room_sum = {1'b0, level} + {1'b0, inflight};
   assign fetch_req = run_q && !halt && !flush && (room_sum < LW1'(DEPTH)) && (inflight < LW'(MAX_OUTST));
   assign granted  = fetch_req && fetch_gnt;
   assign accept   = code_valid && !flush && (drop_cnt == '0) && (live_cnt != '0);
   assign drop_hit = code_valid && (drop_cnt != '0);
   assign resp_hit = code_valid && (inflight != '0);
   assign pc_fetch = pc_q;

`ifdef FETCH_BUF_BYPASS_EN
   assign byp_take = accept && fifo_empty && out_ready;
`else
   assign byp_take = 1'b0;
`endif

   assign wr_ent.code = code_fetch;
   assign wr_ent.pc   = pcq[pcq_rd];

   rv32_sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (flush),
      .wr_en  (accept && !byp_take),
      .wr_dat (wr_ent),
      .rd_en  (out_ready),
      .rd_dat (rd_ent),
      .level  (level),
      .empty  (fifo_empty)
   );

   assign out_valid = !fifo_empty || byp_take;
   assign code_out  = byp_take ? code_fetch : (fifo_empty ? '0 : rd_ent.code);
   assign pc_out    = byp_take ? wr_ent.pc  : (fifo_empty ? '0 : rd_ent.pc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         pc_q     <= RESET_PC;
         pcq_wr   <= '0;
         pcq_rd   <= '0;
         live_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         run_q <= 1'b1;
         if (flush) begin
            // anything still on the bus belongs to the old stream
            pc_q     <= redirect_pc;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            live_cnt <= '0;
            drop_cnt <= inflight - {{(LW-1){1'b0}}, resp_hit};
         end else begin
            if (granted) begin
               pc_q   <= pc_q + PC_INCR;
               pcq_wr <= pcq_wr + 1'b1;
            end
            if (accept) pcq_rd <= pcq_rd + 1'b1;
            live_cnt <= live_cnt + {{(LW-1){1'b0}}, granted} - {{(LW-1){1'b0}}, accept};
            if (drop_hit) drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (granted) pcq[pcq_wr] <= pc_q;
   end
endmodule

// File: tb/tb_rv32_fetch_buffer.sv
// Randomized bench for rv32_fetch_buffer: a memory responder, a program-order reference model,
// and a scoreboard monitor that checks every entry handed to decode.
module tb_rv32_fetch_buffer;
   localparam int          DEPTH     = 4;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'h0;
`ifdef FETCH_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_fetch;
   logic        fetch_req;
   logic        fetch_gnt = 1'b0;
   logic        code_valid = 1'b0;
   logic [31:0] code_fetch = '0;
   logic        flush = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] code_out;
   logic [31:0] pc_out;
   logic [2:0]  level;

   always #5 clk = ~clk;

   rv32_fetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .pc_fetch(pc_fetch), .fetch_req(fetch_req), .fetch_gnt(fetch_gnt),
      .code_valid(code_valid), .code_fetch(code_fetch), .flush(flush), .redirect_pc(redirect_pc),
      .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
      .pc_out(pc_out), .level(level)
   );

   typedef struct { logic [31:0] pc; logic [31:0] code; int wt; bit stale; } bus_t;
   typedef struct { logic [31:0] pc; logic [31:0] code; } exp_t;

   bus_t bus[$];      // requests granted on the bus, oldest first
   exp_t exp_q[$];    // program-order entries decode should still see
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] m_pc;
   int   m_lvl;
   int   p_gnt, p_rdy, p_halt, p_flush, min_wt, max_wt;
   bit   f_flush;
   logic [31:0] f_redir;

   function automatic logic [31:0] code_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // scoreboard monitor: compares every accepted head against program order
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: pc_out %h, expected no entry", pc_out);
            end else begin
               e = exp_q.pop_front();
               chk("pc_out", pc_out, e.pc);
               chk("code_out", code_out, e.code);
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      fetch_gnt = 1'b0; code_valid = 1'b0; flush = 1'b0; halt = 1'b0; out_ready = 1'b0;
      #2;
      chk("rst_fetch_req", 32'(fetch_req), 32'd0);
      chk("rst_pc_fetch", pc_fetch, RESET_PC);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_code_out", code_out, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      bus.delete();
      exp_q.delete();
      m_pc  = RESET_PC;
      m_lvl = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic do_cycle();
      bit   cv, exp_req, byp, pop;
      int   infl;
      bus_t b;
      bus_t nb;
      exp_t e;
      @(posedge clk);
      #1;
      fetch_gnt   = ($urandom_range(0, 99) < p_gnt);
      out_ready   = ($urandom_range(0, 99) < p_rdy);
      halt        = ($urandom_range(0, 99) < p_halt);
      flush       = f_flush || ($urandom_range(0, 99) < p_flush);
      redirect_pc = f_flush ? f_redir : ($urandom() & 32'h0000_0FFC);
      cv = 1'b0;
      if (bus.size() > 0) begin
         if (bus[0].wt == 0) cv = 1'b1;
         else bus[0].wt = bus[0].wt - 1;
      end
      code_valid = cv;
      code_fetch = cv ? bus[0].code : $urandom();
      @(negedge clk);
      infl    = bus.size();
      exp_req = !halt && !flush && (m_lvl + infl < DEPTH) && (infl < MAX_OUTST);
      chk("fetch_req", 32'(fetch_req), 32'(exp_req));
      if (exp_req) chk("pc_fetch", pc_fetch, m_pc);
      chk("level", 32'(level), 32'(m_lvl));
      byp = BYP && cv && !bus[0].stale && !flush && (m_lvl == 0) && out_ready;
      chk("out_valid", 32'(out_valid), 32'((m_lvl != 0) || byp));
      pop = !flush && out_ready && (m_lvl != 0);
      if (cv) b = bus.pop_front();
      if (flush) begin
         m_lvl = 0;
         m_pc  = redirect_pc;
         foreach (bus[i]) bus[i].stale = 1'b1;
         exp_q.delete();
      end else begin
         if (cv && !b.stale && !byp) m_lvl++;
         if (pop) m_lvl--;
         if (exp_req && fetch_gnt) begin
            nb.pc = pc_fetch; nb.code = code_of(pc_fetch);
            nb.wt = $urandom_range(min_wt, max_wt); nb.stale = 1'b0;
            bus.push_back(nb);
            e.pc = m_pc; e.code = code_of(m_pc);
            exp_q.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   initial begin
      bit seen;
      f_flush = 1'b0; f_redir = '0;
      p_gnt = 100; p_rdy = 100; p_halt = 0; p_flush = 0; min_wt = 0; max_wt = 0;
      do_reset();

      // streaming with immediate grants and responses
      repeat (12) begin
         do_cycle();
         chk("stream_level_le1", 32'(level <= 3'd1), 32'd1);
      end

      // decode stalled: buffer fills, then drains in order
      do_reset();
      p_rdy = 0;
      repeat (12) do_cycle();
      chk("full_level", 32'(level), 32'd4);
      chk("full_fetch_req", 32'(fetch_req), 32'd0);
      p_gnt = 0; p_rdy = 100;
      repeat (8) do_cycle();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      // flush with two requests in flight
      do_reset();
      p_gnt = 100; p_rdy = 100; min_wt = 4; max_wt = 4;
      for (int i = 0; i < 20 && bus.size() < 2; i++) do_cycle();
      chk("two_outstanding", 32'(bus.size()), 32'd2);
      f_flush = 1'b1; f_redir = 32'h100;
      do_cycle();
      f_flush = 1'b0; min_wt = 0; max_wt = 0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         do_cycle();
         if (out_valid && out_ready && !flush) begin
            seen = 1'b1;
            chk("first_after_flush", pc_out, 32'h100);
         end
      end
      if (!seen) chk("first_after_flush_seen", 32'd0, 32'd1);

      // halt with one request in flight
      do_reset();
      p_gnt = 100; p_rdy = 0; min_wt = 3; max_wt = 3;
      for (int i = 0; i < 10 && bus.size() < 1; i++) do_cycle();
      p_halt = 100;
      repeat (8) do_cycle();
      chk("halt_level", 32'(level), 32'd1);
      chk("halt_fetch_req", 32'(fetch_req), 32'd0);
      p_halt = 0; p_rdy = 100; min_wt = 0; max_wt = 0;
      repeat (6) do_cycle();

      // random traffic, with a reset in the middle
      p_gnt = 70; p_rdy = 60; p_halt = 10; p_flush = 3; min_wt = 0; max_wt = 3;
      repeat (1500) do_cycle();
      do_reset();
      repeat (1500) do_cycle();

      p_halt = 100; p_flush = 0; p_rdy = 100; max_wt = 0;
      repeat (20) do_cycle();
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
